// File: rtl/whack_draw_sequencer_pkg.sv
// Purpose: shared state encoding, grid geometry and default colours for the draw sequencer.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
// Contents: state_t, NUM_HOLES, GRID_COLS, DEF_UP_COLOUR/DEF_DOWN_COLOUR, hole_col()/hole_row().
package whack_pkg;

    localparam int NUM_HOLES = 9;
    localparam int GRID_COLS = 3;

    localparam logic [2:0] DEF_UP_COLOUR   = 3'b110;
    localparam logic [2:0] DEF_DOWN_COLOUR = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SET_X,
        SET_Y,
        RELEASE,
        WAIT_DONE,
        FINISH
    } state_t;

    // Grid column of a hole index (holes are numbered row-major).
    function automatic logic [1:0] hole_col(input logic [3:0] idx);
        return 2'(int'(idx) % GRID_COLS);
    endfunction

    // Grid row of a hole index.
    function automatic logic [1:0] hole_row(input logic [3:0] idx);
        return 2'(int'(idx) / GRID_COLS);
    endfunction

endpackage

// File: rtl/whack_draw_sequencer_if.sv
// Purpose: bundle of the mask-update input, plotter handshake and status outputs.
// Latency: n/a (wires only).
// Backpressure: the plotter throttles the sequencer through iDone.
// Ports: master = sequencer side (drives plotter controls), slave = surrounding logic / plotter side.
interface whack_draw_sequencer_if;

    logic [8:0] iHoleMask;
    logic       iUpdate;
    logic       iDone;
    logic       oLoadX;
    logic       oPlotBox;
    logic [6:0] oXY_Coord;
    logic [2:0] oColour;
    logic       oBusy;
    logic       oFrameDone;

    modport master (
        input  iHoleMask, iUpdate, iDone,
        output oLoadX, oPlotBox, oXY_Coord, oColour, oBusy, oFrameDone
    );

    modport slave (
        output iHoleMask, iUpdate, iDone,
        input  oLoadX, oPlotBox, oXY_Coord, oColour, oBusy, oFrameDone
    );

endinterface

// File: rtl/whack_draw_sequencer_hole_coord_lut.sv
// Purpose: maps a hole index to the top-left pixel of its 4x4 box.
// Latency: combinational.
// Backpressure: none.
// Ports: idx (hole 0..8) in; x, y (7-bit pixel coordinates) out.
module hole_coord_lut
    import whack_pkg::*;
#(
    parameter int X_ORIGIN = 20,
    parameter int Y_ORIGIN = 20,
    parameter int X_PITCH  = 40,
    parameter int Y_PITCH  = 35
) (
    input  logic [3:0] idx,
    output logic [6:0] x,
    output logic [6:0] y
);

    logic [1:0] col;
    logic [1:0] row;

    assign col = hole_col(idx);
    assign row = hole_row(idx);

    // 7-bit arithmetic wraps identically to truncating an 8-bit sum, so the
    // dropped MSB never needs to exist.
    assign x = 7'(X_ORIGIN) + 7'(X_PITCH) * {5'd0, col};
    assign y = 7'(Y_ORIGIN) + 7'(Y_PITCH) * {5'd0, row};

endmodule

// File: rtl/whack_draw_sequencer.sv
// Purpose: walks the 3x3 hole mask and issues one LoadX/PlotBox box command per hole.
// Latency: 1 cycle update->SCAN; per drawn hole 6 + (DONE_GUARD+1 or more) cycles, per skipped hole 1.
// Backpressure: stalls in WAIT_DONE until iDone; updates arriving while busy coalesce into one pending frame.
// Ports: iClock, iResetn (async active-low) plain; bus (master modport) carries mask/update, plotter controls, status.
// Option: WHACK_DIFF_REDRAW_EN redraws only holes that changed since the last frame (all holes on the first frame).
module whack_draw_sequencer
    import whack_pkg::*;
#(
    parameter int         X_ORIGIN    = 20,
    parameter int         Y_ORIGIN    = 20,
    parameter int         X_PITCH     = 40,
    parameter int         Y_PITCH     = 35,
    parameter logic [2:0] UP_COLOUR   = DEF_UP_COLOUR,
    parameter logic [2:0] DOWN_COLOUR = DEF_DOWN_COLOUR,
    parameter int         DONE_GUARD  = 2
) (
    input  logic                   iClock,
    input  logic                   iResetn,
    whack_draw_sequencer_if.master bus
);

    localparam int              CW        = $clog2(DONE_GUARD + 2);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   GUARD_CNT = CW'(DONE_GUARD);
    localparam logic [3:0]      LAST_IDX  = 4'(NUM_HOLES - 1);

    state_t        state, state_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [8:0]    work;
    logic [8:0]    pend_mask;
    logic          pending;
    logic          need_draw;
    logic [6:0]    hole_x;
    logic [6:0]    hole_y;

    hole_coord_lut #(
        .X_ORIGIN (X_ORIGIN),
        .Y_ORIGIN (Y_ORIGIN),
        .X_PITCH  (X_PITCH),
        .Y_PITCH  (Y_PITCH)
    ) u_lut (
        .idx (idx),
        .x   (hole_x),
        .y   (hole_y)
    );

`ifdef WHACK_DIFF_REDRAW_EN
    logic [8:0] shadow;
    logic       first_frame;

    // Shadow holds what is on screen; first frame after reset paints everything.
    assign need_draw = first_frame || (work[idx] != shadow[idx]);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            shadow      <= '0;
            first_frame <= 1'b1;
        end else if (state == FINISH) begin
            shadow      <= work;
            first_frame <= 1'b0;
        end
    end
`else
    assign need_draw = 1'b1;
`endif

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Mask capture: IDLE starts a frame (a fresh strobe beats a stale pending
    // mask); any strobe while busy, including in FINISH, overwrites pending.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            work      <= '0;
            pend_mask <= '0;
            pending   <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.iUpdate || pending) begin
                work    <= bus.iUpdate ? bus.iHoleMask : pend_mask;
                pending <= 1'b0;
            end
        end else if (bus.iUpdate) begin
            pending   <= 1'b1;
            pend_mask <= bus.iHoleMask;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.iUpdate || pending) begin
                    idx_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (need_draw) begin
                    cnt_nxt   = '0;
                    state_nxt = SET_X;
                end else if (idx == LAST_IDX) begin
                    state_nxt = FINISH;
                end else begin
                    idx_nxt = idx + 4'd1;
                end
            end
            SET_X: begin
                if (cnt == CNT_ONE) begin
                    cnt_nxt   = '0;
                    state_nxt = SET_Y;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            SET_Y: begin
                if (cnt == CNT_ONE) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            RELEASE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // The plotter's oDone from the previous box is still high for
                // a few cycles after PlotBox; only trust it after the guard.
                if (cnt != GUARD_CNT) begin
                    cnt_nxt = cnt + CNT_ONE;
                end else if (bus.iDone) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = FINISH;
                    end else begin
                        idx_nxt   = idx + 4'd1;
                        state_nxt = SCAN;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset forces them low at once.
    always_comb begin
        bus.oLoadX    = 1'b0;
        bus.oPlotBox  = 1'b0;
        bus.oXY_Coord = '0;
        bus.oColour   = '0;
        case (state)
            SET_X: begin
                bus.oLoadX    = 1'b1;
                bus.oXY_Coord = hole_x;
            end
            SET_Y: begin
                bus.oPlotBox  = 1'b1;
                bus.oXY_Coord = hole_y;
            end
            RELEASE, WAIT_DONE: begin
                bus.oXY_Coord = hole_y;
            end
            default: begin
            end
        endcase
        if (state inside {SET_X, SET_Y, RELEASE, WAIT_DONE}) begin
            bus.oColour = work[idx] ? UP_COLOUR : DOWN_COLOUR;
        end
    end

    assign bus.oBusy      = (state != IDLE);
    assign bus.oFrameDone = (state == FINISH);

endmodule

// File: tb/tb_whack_draw_sequencer.sv
// Purpose: directed self-checking bench for whack_draw_sequencer with a simple plotter model.
// Latency: n/a.
// Backpressure: plotter model drops iDone during PlotBox and raises it 3 cycles later (or is driven by hand).
module tb_whack_draw_sequencer;

`ifdef WHACK_DIFF_REDRAW_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic iClock  = 1'b0;
    logic iResetn = 1'b1;

    always #5 iClock = ~iClock;

    whack_draw_sequencer_if bus();

    whack_draw_sequencer dut (
        .iClock  (iClock),
        .iResetn (iResetn),
        .bus     (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int cyc_now  = 0;
    int fd_cnt   = 0;
    int plot_cyc = 0;
    int done_cd  = 0;
    bit auto_done = 1'b1;
    logic prev_loadx = 1'b0;
    logic prev_plot  = 1'b0;
    logic [6:0] draw_x[$];
    logic [6:0] draw_y[$];
    logic [2:0] draw_c[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, log plotter traffic, run the iDone model.
    task automatic step();
        @(negedge iClock);
        cyc_now++;
        if (bus.oLoadX && !prev_loadx) begin
            draw_x.push_back(bus.oXY_Coord);
            draw_c.push_back(bus.oColour);
        end
        if (bus.oPlotBox && !prev_plot) draw_y.push_back(bus.oXY_Coord);
        if (bus.oPlotBox) plot_cyc++;
        if (bus.oFrameDone) fd_cnt++;
        prev_loadx = bus.oLoadX;
        prev_plot  = bus.oPlotBox;
        if (auto_done) begin
            if (bus.oPlotBox) begin
                bus.iDone = 1'b0;
                done_cd   = 3;
            end else if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) bus.iDone = 1'b1;
            end
        end
    endtask

    task automatic clear_log();
        draw_x.delete();
        draw_y.delete();
        draw_c.delete();
        plot_cyc = 0;
        fd_cnt   = 0;
    endtask

    task automatic strobe(input logic [8:0] m);
        bus.iHoleMask = m;
        bus.iUpdate   = 1'b1;
        step();
        bus.iUpdate   = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        while (!bus.oFrameDone && n < 400) begin
            step();
            n++;
        end
        check({tag, "_frame_done_seen"}, bus.oFrameDone, 1);
    endtask

    initial begin
        int t0;
        int n;
        bus.iHoleMask = '0;
        bus.iUpdate   = 1'b0;
        bus.iDone     = 1'b1;
        #1 iResetn = 1'b0;
        repeat (3) step();
        check("rst_loadx", bus.oLoadX, 0);
        check("rst_plot",  bus.oPlotBox, 0);
        check("rst_busy",  bus.oBusy, 0);
        check("rst_fd",    bus.oFrameDone, 0);
        check("rst_xy",    bus.oXY_Coord, 0);
        check("rst_col",   bus.oColour, 0);
        iResetn = 1'b1;
        step();
        check("idle_busy", bus.oBusy, 0);

        // Frame 1: mask 001, every hole drawn in both builds.
        clear_log();
        t0 = cyc_now;
        strobe(9'h001);
        check("f1_scan_busy",  bus.oBusy, 1);
        check("f1_scan_loadx", bus.oLoadX, 0);
        step();
        check("f1_setx_loadx", bus.oLoadX, 1);
        check("f1_setx_x",     bus.oXY_Coord, 20);
        wait_fd("f1");
        check("f1_len",   cyc_now - t0, 82);
        check("f1_draws", draw_x.size(), 9);
        check("f1_x0", draw_x[0], 20);
        check("f1_y0", draw_y[0], 20);
        check("f1_c0", draw_c[0], 3'b110);
        check("f1_x8", draw_x[8], 100);
        check("f1_y8", draw_y[8], 90);
        check("f1_c8", draw_c[8], 3'b001);
        check("f1_plot_cycles", plot_cyc, 18);
        step();
        check("f1_fd_width", bus.oFrameDone, 0);
        check("f1_busy_fall", bus.oBusy, 0);
        check("f1_fd_count", fd_cnt, 1);

        // Frame 2: mask 011, only hole 4 changes.
        clear_log();
        strobe(9'h011);
        wait_fd("f2");
        check("f2_draws", draw_x.size(), DIFF ? 1 : 9);
        check("f2_x4", draw_x[DIFF ? 0 : 4], 60);
        check("f2_y4", draw_y[DIFF ? 0 : 4], 55);
        check("f2_c4", draw_c[DIFF ? 0 : 4], 3'b110);

        // Frame 3: identical mask.
        step();
        clear_log();
        t0 = cyc_now;
        strobe(9'h011);
        wait_fd("f3");
        check("f3_len",   cyc_now - t0, DIFF ? 10 : 82);
        check("f3_draws", draw_x.size(), DIFF ? 0 : 9);
        check("f3_plot_cycles", plot_cyc, DIFF ? 0 : 18);

        // Frames 4/5: three strobes mid-frame coalesce to a single 002 frame.
        step();
        clear_log();
        strobe(9'h000);
        repeat (2) step();
        strobe(9'h100);
        repeat (2) step();
        strobe(9'h0FF);
        repeat (2) step();
        strobe(9'h002);
        wait_fd("f4");
        check("f4_draws", draw_x.size(), DIFF ? 2 : 9);
        clear_log();
        step();
        check("f5_gap_idle", bus.oBusy, 0);
        step();
        check("f5_restart", bus.oBusy, 1);
        wait_fd("f5");
        check("f5_draws", draw_x.size(), DIFF ? 1 : 9);
        check("f5_x_first", draw_x[0], DIFF ? 60 : 20);
        check("f5_c_first", draw_c[0], DIFF ? 3'b110 : 3'b001);
        check("f5_c_hole1", draw_c[DIFF ? 0 : 1], 3'b110);
        repeat (20) step();
        check("f5_single_followon", fd_cnt, 1);
        check("f5_idle", bus.oBusy, 0);

        // Frames 6/7: strobe lands in the FINISH cycle.
        clear_log();
        t0 = cyc_now;
        strobe(9'h002);
        wait_fd("f6");
        check("f6_len", cyc_now - t0, DIFF ? 10 : 82);
        clear_log();
        strobe(9'h1FF);
        check("f7_gap_idle", bus.oBusy, 0);
        step();
        check("f7_restart", bus.oBusy, 1);
        wait_fd("f7");
        check("f7_draws", draw_x.size(), DIFF ? 8 : 9);
        check("f7_x_first", draw_x[0], 20);
        check("f7_c_first", draw_c[0], 3'b110);

        // Frame 8: stale iDone across the guard, then a long low phase.
        step();
        clear_log();
        auto_done = 1'b0;
        bus.iDone = 1'b1;
        strobe(9'h000);
        n = 0;
        while (!bus.oPlotBox && n < 50) begin step(); n++; end
        check("f8_reach_plot", bus.oPlotBox, 1);
        n = 0;
        while (bus.oPlotBox && n < 10) begin step(); n++; end
        check("f8_release_xy", bus.oXY_Coord, 20);
        step();
        check("f8_w0_xy", bus.oXY_Coord, 20);
        step();
        check("f8_w1_xy", bus.oXY_Coord, 20);
        step();
        check("f8_w2_xy", bus.oXY_Coord, 20);
        bus.iDone = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("f8_hold_busy",  bus.oBusy, 1);
            check("f8_hold_loadx", bus.oLoadX, 0);
            check("f8_hold_xy",    bus.oXY_Coord, 20);
        end
        bus.iDone = 1'b1;
        n = 0;
        while (!bus.oLoadX && n < 5) begin step(); n++; end
        check("f8_next_loadx", bus.oLoadX, 1);
        check("f8_next_x",     bus.oXY_Coord, 60);
        check("f8_next_delay", n, 2);
        auto_done = 1'b1;
        wait_fd("f8");
        check("f8_draws", draw_x.size(), 9);
        check("f8_c0", draw_c[0], 3'b001);

        // Frame 9: reset dropped during SET_Y.
        step();
        clear_log();
        strobe(9'h1FF);
        n = 0;
        while (!bus.oPlotBox && n < 50) begin step(); n++; end
        check("f9_in_sety", bus.oPlotBox, 1);
        #1 iResetn = 1'b0;
        #1;
        check("f9_arst_loadx", bus.oLoadX, 0);
        check("f9_arst_plot",  bus.oPlotBox, 0);
        check("f9_arst_busy",  bus.oBusy, 0);
        check("f9_arst_fd",    bus.oFrameDone, 0);
        check("f9_arst_xy",    bus.oXY_Coord, 0);
        check("f9_arst_col",   bus.oColour, 0);
        repeat (2) step();
        iResetn = 1'b1;
        repeat (3) step();
        check("f9_idle_after", bus.oBusy, 0);

        // Frame 10: fresh frame after reset paints every hole again.
        clear_log();
        t0 = cyc_now;
        strobe(9'h155);
        wait_fd("f10");
        check("f10_len",   cyc_now - t0, 82);
        check("f10_draws", draw_x.size(), 9);
        check("f10_c0", draw_c[0], 3'b110);
        check("f10_c1", draw_c[1], 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
